// File: rtl/alu_instr_sequencer.sv
// alu_instr_sequencer: hardwired fetch/execute sequencer for 3-register ALU instructions
// with Run/Instr_Done handshake, memory-ready timeout, illegal-opcode fault and instruction count.
module alu_instr_sequencer #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 4,
   parameter int CTRL_WIDTH     = 4,
   parameter int ALU_OP_MAX     = 11,
   parameter int MEM_TIMEOUT    = 15,
   parameter int COUNT_WIDTH    = 16
)(
   input  logic                      Clock,
   input  logic                      Reset,
   input  logic                      Run,
   input  logic                      Mem_Ready,
   input  logic [DATA_WIDTH-1:0]     IR_Word,
   output logic                      PC_Out,
   output logic                      ZLO_Out,
   output logic                      MDR_Out,
   output logic                      Reg_Out_En,
   output logic                      MAR_In,
   output logic                      PC_In,
   output logic                      MDR_In,
   output logic                      IR_In,
   output logic                      Y_In,
   output logic                      Z_In,
   output logic                      Reg_In_En,
   output logic                      IncPC,
   output logic                      Read,
   output logic [REG_ADDR_WIDTH-1:0] Reg_Out_Sel,
   output logic [REG_ADDR_WIDTH-1:0] Reg_In_Sel,
   output logic [CTRL_WIDTH-1:0]     CONTROL,
   output logic                      Instr_Done,
   output logic                      Fault,
   output logic [COUNT_WIDTH-1:0]    Instr_Count
);
   localparam int OPW   = 5;
   localparam int RA_LO = DATA_WIDTH - OPW - REG_ADDR_WIDTH;
   localparam int RB_LO = RA_LO - REG_ADDR_WIDTH;
   localparam int RC_LO = RB_LO - REG_ADDR_WIDTH;
   localparam int WW    = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [3:0] {IDLE, T0, T1, TM, T2, T3, T4, T5, FAULT} state_t;

   state_t state, next;
   logic [WW-1:0] wait_cnt;
   logic [OPW-1:0] opcode;
   logic [REG_ADDR_WIDTH-1:0] ra, rb, rc;
   logic illegal, ir_unused;

   assign opcode    = IR_Word[DATA_WIDTH-1 -: OPW];
   assign ra        = IR_Word[RA_LO +: REG_ADDR_WIDTH];
   assign rb        = IR_Word[RB_LO +: REG_ADDR_WIDTH];
   assign rc        = IR_Word[RC_LO +: REG_ADDR_WIDTH];
   assign illegal   = opcode > OPW'(ALU_OP_MAX);
   assign ir_unused = ^IR_Word[RC_LO-1:0];

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         Instr_Count <= '0;
      end else begin
         state       <= next;
         wait_cnt    <= (state == TM && !Mem_Ready) ? wait_cnt + WW'(1) : '0;
         Instr_Count <= (state == T5) ? Instr_Count + COUNT_WIDTH'(1) : Instr_Count;
      end
   end

   // Wait counter holds the number of already-elapsed TM cycles, so the last allowed one is MEM_TIMEOUT-1.
   always_comb begin
      next        = state;
      PC_Out      = 1'b0;
      ZLO_Out     = 1'b0;
      MDR_Out     = 1'b0;
      Reg_Out_En  = 1'b0;
      MAR_In      = 1'b0;
      PC_In       = 1'b0;
      MDR_In      = 1'b0;
      IR_In       = 1'b0;
      Y_In        = 1'b0;
      Z_In        = 1'b0;
      Reg_In_En   = 1'b0;
      IncPC       = 1'b0;
      Read        = 1'b0;
      Reg_Out_Sel = '0;
      Reg_In_Sel  = '0;
      CONTROL     = '0;
      Instr_Done  = 1'b0;
      Fault       = 1'b0;
      case (state)
         IDLE: next = Run ? T0 : IDLE;
         T0: begin
            PC_Out = 1'b1;
            MAR_In = 1'b1;
            IncPC  = 1'b1;
            Z_In   = 1'b1;
            next   = T1;
         end
         T1: begin
            ZLO_Out = 1'b1;
            PC_In   = 1'b1;
            next    = TM;
         end
         TM: begin
            Read   = 1'b1;
            MDR_In = Mem_Ready;
            next   = Mem_Ready ? T2 : (wait_cnt == WW'(MEM_TIMEOUT - 1)) ? FAULT : TM;
         end
         T2: begin
            MDR_Out = 1'b1;
            IR_In   = 1'b1;
            next    = T3;
         end
         T3: begin
            Reg_Out_En  = !illegal;
            Reg_Out_Sel = illegal ? '0 : rb;
            Y_In        = !illegal;
            next        = illegal ? FAULT : T4;
         end
         T4: begin
            Reg_Out_En  = 1'b1;
            Reg_Out_Sel = rc;
            CONTROL     = opcode[CTRL_WIDTH-1:0];
            Z_In        = 1'b1;
            next        = T5;
         end
         T5: begin
            ZLO_Out    = 1'b1;
            Reg_In_En  = 1'b1;
            Reg_In_Sel = ra;
            Instr_Done = 1'b1;
            next       = Run ? T0 : IDLE;
         end
         FAULT: Fault = 1'b1;
         default: next = IDLE;
      endcase
   end
endmodule
